// File: rtl/dut_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : dut_sequencer_if
//  Purpose  : Bundles the host command/response handshake and the DUT test
//             environment control/return lines of dut_sequencer.
//  Ports    : none. Modports:
//               slave  - sequencer view (takes commands, drives environment)
//               master - host + environment view (issues commands, answers)
//  Revision : 1.0 - initial release
// ============================================================================
interface dut_sequencer_if #(
    parameter int BITWIDTH_DATA   = 16,
    parameter int BITWIDTH_ADR    = 6,
    parameter int BITWIDTH_SEL    = 3,
    parameter int NUM_BITS_HEADER = 32
);
    // Host command channel
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [1:0]                 cmd_op;
    logic [BITWIDTH_SEL-1:0]    cmd_sel;
    logic [BITWIDTH_ADR-1:0]    cmd_adr;
    logic [BITWIDTH_DATA-1:0]   cmd_data;

    // Host response channel
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [NUM_BITS_HEADER-1:0] rsp_data;
    logic [1:0]                 rsp_status;

    // DUT test environment
    logic [BITWIDTH_SEL-1:0]    dut_sel;
    logic [BITWIDTH_ADR-1:0]    dut_adr;
    logic                       dut_rnw;
    logic [BITWIDTH_DATA-1:0]   dut_data_in;
    logic                       dut_start;
    logic [BITWIDTH_DATA-1:0]   dut_data_out;
    logic [NUM_BITS_HEADER-1:0] dut_head;
    logic                       dut_rdy;

    modport slave (
        input  cmd_valid, cmd_op, cmd_sel, cmd_adr, cmd_data,
        output cmd_ready,
        output rsp_valid, rsp_data, rsp_status,
        input  rsp_ready,
        output dut_sel, dut_adr, dut_rnw, dut_data_in, dut_start,
        input  dut_data_out, dut_head, dut_rdy
    );

    modport master (
        output cmd_valid, cmd_op, cmd_sel, cmd_adr, cmd_data,
        input  cmd_ready,
        input  rsp_valid, rsp_data, rsp_status,
        output rsp_ready,
        input  dut_sel, dut_adr, dut_rnw, dut_data_in, dut_start,
        output dut_data_out, dut_head, dut_rdy
    );
endinterface
`default_nettype wire

// File: rtl/dut_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : dut_sequencer
//  Purpose  : Executes one host command at a time (HEAD / WRITE / READ) against
//             the DUT test environment: drives select/address/data/RnW, pulses
//             start, waits for the DUT ready flag with a bounded timeout and
//             returns the captured word plus a status code.
//  Ports    : clk_sys - system clock, rising edge
//             rstn    - asynchronous active-low reset
//             bus     - dut_sequencer_if.slave (command, response, environment)
//             busy    - high whenever the sequencer is not idle
//  Revision : 1.0 - initial release
// ============================================================================
module dut_sequencer #(
    parameter int BITWIDTH_DATA   = 16,
    parameter int BITWIDTH_ADR    = 6,
    parameter int BITWIDTH_SEL    = 3,
    parameter int NUM_BITS_HEADER = 32,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  wire logic      clk_sys,
    input  wire logic      rstn,
    dut_sequencer_if.slave bus,
    output logic           busy
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_SETUP  = 3'd1;
    localparam logic [2:0] c_ST_STROBE = 3'd2;
    localparam logic [2:0] c_ST_WAIT   = 3'd3;
    localparam logic [2:0] c_ST_RESP   = 3'd4;

    localparam logic [1:0] c_OP_HEAD  = 2'd0;
    localparam logic [1:0] c_OP_WRITE = 2'd1;
    localparam logic [1:0] c_OP_RSVD  = 2'd3;

    localparam logic [1:0] c_STS_OK      = 2'b00;
    localparam logic [1:0] c_STS_TIMEOUT = 2'b01;
    localparam logic [1:0] c_STS_BAD_SEL = 2'b10;
    localparam logic [1:0] c_STS_BAD_OP  = 2'b11;

    // Timer counts 0 .. TIMEOUT_CYCLES-1 inside WAIT
    localparam int c_TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT_CYCLES - 1);

    // Common width for comparing SEL against the 6-bit NUM_DUT header field
    localparam int c_CMP_W = (BITWIDTH_SEL > 6) ? BITWIDTH_SEL : 6;

    logic [2:0]                 r_state;
    logic                       r_live;
    logic [1:0]                 r_op;
    logic [BITWIDTH_SEL-1:0]    r_dut_sel;
    logic [BITWIDTH_ADR-1:0]    r_dut_adr;
    logic                       r_dut_rnw;
    logic [BITWIDTH_DATA-1:0]   r_dut_data_in;
    logic [NUM_BITS_HEADER-1:0] r_rsp_data;
    logic [1:0]                 r_rsp_status;
    logic [c_TMR_W-1:0]         r_timer;

    logic                       w_cmd_ready;
    logic [c_CMP_W-1:0]         w_sel_cmp;
    logic [c_CMP_W-1:0]         w_num_dut;
    logic                       w_sel_bad;

    // r_live holds CMD_READY low while reset is asserted and lets it rise on
    // the first clock after reset release, keeping it a register decode.
    assign w_cmd_ready = r_live && (r_state == c_ST_IDLE);

    // The header seen in SETUP belongs to the DUT selected at accept time.
    assign w_sel_cmp = c_CMP_W'(r_dut_sel);
    assign w_num_dut = c_CMP_W'(bus.dut_head[NUM_BITS_HEADER-1 -: 6]);
    assign w_sel_bad = (r_dut_sel == '0) || (w_sel_cmp > w_num_dut);

    always_ff @(posedge clk_sys or negedge rstn) begin
        if (!rstn) begin
            r_state       <= c_ST_IDLE;
            r_live        <= 1'b0;
            r_op          <= 2'd0;
            r_dut_sel     <= '0;
            r_dut_adr     <= '0;
            r_dut_rnw     <= 1'b0;
            r_dut_data_in <= '0;
            r_rsp_data    <= '0;
            r_rsp_status  <= 2'b00;
            r_timer       <= '0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.cmd_valid && w_cmd_ready) begin
                        r_op          <= bus.cmd_op;
                        r_dut_sel     <= bus.cmd_sel;
                        r_dut_adr     <= bus.cmd_adr;
                        r_dut_data_in <= bus.cmd_data;
                        r_dut_rnw     <= (bus.cmd_op != c_OP_WRITE);
                        r_state       <= c_ST_SETUP;
                    end
                end
                c_ST_SETUP: begin
                    if (r_op == c_OP_RSVD) begin
                        r_rsp_data   <= '0;
                        r_rsp_status <= c_STS_BAD_OP;
                        r_state      <= c_ST_RESP;
                    end else if (w_sel_bad) begin
                        r_rsp_data   <= '0;
                        r_rsp_status <= c_STS_BAD_SEL;
                        r_state      <= c_ST_RESP;
                    end else if (r_op == c_OP_HEAD) begin
                        r_rsp_data   <= bus.dut_head;
                        r_rsp_status <= c_STS_OK;
                        r_state      <= c_ST_RESP;
                    end else begin
                        r_state <= c_ST_STROBE;
                    end
                end
                c_ST_STROBE: begin
                    r_timer <= '0;
                    r_state <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    // Ready on the final cycle takes precedence over timeout
                    if (bus.dut_rdy) begin
                        r_rsp_data   <= NUM_BITS_HEADER'(bus.dut_data_out);
                        r_rsp_status <= c_STS_OK;
                        r_state      <= c_ST_RESP;
                    end else if (r_timer == c_TMR_LAST) begin
                        r_rsp_data   <= '0;
                        r_rsp_status <= c_STS_TIMEOUT;
                        r_state      <= c_ST_RESP;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                c_ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_dut_sel <= '0;
                        r_state   <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = w_cmd_ready;
    assign bus.rsp_valid   = (r_state == c_ST_RESP);
    assign bus.dut_start   = (r_state == c_ST_STROBE);
    assign busy            = (r_state != c_ST_IDLE);

    assign bus.rsp_data    = r_rsp_data;
    assign bus.rsp_status  = r_rsp_status;
    assign bus.dut_sel     = r_dut_sel;
    assign bus.dut_adr     = r_dut_adr;
    assign bus.dut_rnw     = r_dut_rnw;
    assign bus.dut_data_in = r_dut_data_in;

endmodule
`default_nettype wire

// File: doc/dut_sequencer.md
# dut_sequencer

Command-driven controller that sequences the FPGA DUT test environment on behalf of the host link. It accepts one command at a time over a valid/ready port and drives the environment's select, address, read/write, data and start lines. It waits for the selected DUT's ready flag with a bounded timeout and returns the captured result or header word over a valid/ready response port. It sits between the host transfer logic and the DUT test environment and is the only block that drives the environment's control inputs.

## Interface
- BITWIDTH_DATA, 16, DUT data bus width
- BITWIDTH_ADR, 6, DUT address width
- BITWIDTH_SEL, 3, DUT select width (matches environment SEL)
- NUM_BITS_HEADER, 32, header width; bits [NUM_BITS_HEADER-1 -: 6] carry NUM_DUT
- TIMEOUT_CYCLES, 1024, maximum WAIT cycles before timeout (>= 1)

Ports:
- CLK_SYS  in  1  system clock; all logic on rising edge
- RSTN  in  1  reset, asynchronous, active-low
- CMD_VALID  in  1  command offered
- CMD_READY  out  1  sequencer can accept a command
- CMD_OP  in  2  0=HEAD, 1=WRITE, 2=READ, 3=reserved
- CMD_SEL  in  BITWIDTH_SEL  target DUT index
- CMD_ADR  in  BITWIDTH_ADR  DUT address
- CMD_DATA  in  BITWIDTH_DATA  write/input data
- RSP_VALID  out  1  response available
- RSP_READY  in  1  host takes response
- RSP_DATA  out  NUM_BITS_HEADER  result, zero-extended
- RSP_STATUS  out  2  00=ok, 01=timeout, 10=bad SEL, 11=bad opcode
- DUT_SEL / DUT_ADR / DUT_RnW / DUT_DATA_IN  out  BITWIDTH_SEL / BITWIDTH_ADR / 1 / BITWIDTH_DATA  registered environment controls
- DUT_START  out  1  single-cycle start strobe
- DUT_DATA_OUT  in  BITWIDTH_DATA  selected DUT data
- DUT_HEAD  in  NUM_BITS_HEADER  selected DUT header
- DUT_RDY  in  1  selected DUT ready flag
- BUSY  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, SETUP, STROBE, WAIT, RESP.
- IDLE: CMD_READY=1. On CMD_VALID&CMD_READY, latch the command fields. Drive DUT_SEL=CMD_SEL, DUT_ADR, DUT_DATA_IN, and DUT_RnW = (CMD_OP!=WRITE). Go to SETUP.
- SETUP (one cycle, lets the environment mux settle). Checks in priority order:
  - opcode 3 -> RESP, status 11;
  - SEL==0 or SEL > DUT_HEAD NUM_DUT field -> RESP, status 10;
  - HEAD -> capture DUT_HEAD into RSP_DATA, status 00, go to RESP;
  - otherwise -> STROBE.
- STROBE: DUT_START=1 for exactly this cycle. Timer cleared. Go to WAIT.
- WAIT: timer increments each cycle.
  - DUT_RDY sampled high -> RSP_DATA = zero-extended DUT_DATA_OUT, status 00, go to RESP.
  - Timer == TIMEOUT_CYCLES-1 and DUT_RDY low -> RSP_DATA=0, status 01, go to RESP.
  - DUT_RDY high on the final cycle wins (status 00).
- RESP: RSP_VALID=1. RSP_DATA and RSP_STATUS are held stable until RSP_READY. On handshake, DUT_SEL returns to 0 (all DUTs disabled) and the FSM goes to IDLE.
- DUT_RDY is ignored outside WAIT, including during STROBE.
- For errors (status 10/11), RSP_DATA=0 and DUT_START is never asserted.

## Timing
- Reset (RSTN low): state IDLE. All outputs 0, including CMD_READY, RSP_VALID, BUSY, DUT_START and DUT_SEL. CMD_READY rises in the first cycle after RSTN deasserts.
- Reset mid-operation: immediate return to IDLE. Any pending response is discarded and DUT_START drops asynchronously.
- Edge E0 = command accepted:
  - HEAD/error: RSP_VALID high after E1.
  - WRITE/READ: DUT_START high between E1 and E2. DUT_RDY is first sampled at E3. RSP_VALID rises at the earliest after E3.
  - Timeout: RSP_VALID after E2+TIMEOUT_CYCLES.
- CMD_READY is low from E0 until the cycle after the response handshake. No back-to-back acceptance in the same cycle as the response handshake.
- Outputs are registered, except CMD_READY, DUT_START, RSP_VALID and BUSY, which are decoded directly from the state register.

## Test plan
- HEAD, SEL=1, DUT_HEAD=0x1000_4010 -> RSP_VALID one cycle after accept, RSP_DATA=0x1000_4010, status 00, DUT_START never high.
- WRITE SEL=3 ADR=5 DATA=0xBEEF, then READ SEL=3 ADR=5, with DUT_RDY raised 4 cycles after the strobe -> each write/read issues exactly one DUT_START pulse; the write sees DUT_RnW=0, the read sees DUT_RnW=1; the read returns RSP_DATA=0x0000_BEEF, status 00.
- READ with DUT_RDY held low, TIMEOUT_CYCLES=8 -> RSP_VALID exactly 8 WAIT cycles after the strobe, status 01, RSP_DATA=0. Repeat with DUT_RDY high on WAIT cycle 8 -> status 00.
- SEL=0, SEL=5 with NUM_DUT=4, and opcode 3 -> status 10, 10 and 11 respectively, no strobe, CMD_READY restored after the handshake.
- RSP_READY held low for 20 cycles -> RSP_VALID/RSP_DATA stable, CMD_READY low, no new command accepted; CMD_VALID asserted throughout is accepted only after the handshake.
- RSTN pulsed low during WAIT -> all outputs 0 at once, no response emitted, the next command executes normally.
